tx_8b10b_encoder: RTL and testbench
===================================

// Module: tx_8b10b_encoder
// PURPOSE
//  TX-path 8b/10b encoder sitting directly upstream of the 10-bit TX serializer.
//  Accepts one byte (data or control) per word period over a valid/ready handshake.
//  Encodes it with running-disparity (RD) tracking and presents a held 10-bit code word.
//  When no byte is offered it fills the slot with the K28.5 comma, so the line never starves.
// PARAMETERS
//  WORD_PERIOD  10     clk cycles per 10-bit word (serializer consumes 1 bit/clk); legal >= 2
//  IDLE_K       8'hBC  control code sent on empty slots (K28.5)
// PORTS
//  clk        in   1   single clock for all logic
//  rst        in   1   reset; synchronous, active-high
//  data_in    in   8   byte HGF_EDCBA; data_in[0] = A
//  k_in       in   1   1 = data_in is a control (K) code
//  valid_in   in   1   data_in/k_in are valid
//  ready_out  out  1   encoder takes a byte this cycle if valid_in=1
//  enc_out    out  10  code word; enc_out[0] = 'a' (first bit on line), order abcdei_fghj
//  word_strb  out  1   one-cycle pulse on the first cycle a new enc_out is presented
//  rd_out     out  1   RD after the current enc_out word; 0 = RD-, 1 = RD+
//  code_err   out  1   one-cycle pulse with word_strb when the word replaced an illegal K code
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high. The reset values are:
//   - slot counter = 0, enc_out = 10'h17C (K28.5, RD-), rd_out = 1
//   - ready_out = 0, word_strb = 0, code_err = 0
//   - Reset mid-word discards any in-flight byte; the next cycle shows the reset values.
//  Slot counter runs 0..WORD_PERIOD-1 and wraps to 0.
//  ready_out is decoded from the counter only: it is 1 iff counter == WORD_PERIOD-1.
//  Handshake:
//   - A transfer occurs iff valid_in && ready_out.
//   - With valid_in=1 and ready_out=0, no byte is consumed; the source must hold its data.
//   - ready_out does not depend on valid_in.
//  Word launch, at the edge leaving counter == WORD_PERIOD-1:
//   - If a transfer occurred, the accepted byte is encoded.
//   - Otherwise IDLE_K is encoded as K.
//   - enc_out, rd_out and code_err update together at that edge; word_strb = 1 for that one cycle.
//   - enc_out is then held stable for exactly WORD_PERIOD cycles.
//  Latency: a byte accepted in cycle N appears on enc_out in cycle N+1.
//  Encoding (IEEE 802.3 cl.36 tables):
//   - EDCBA -> abcdei by the 5b/6b table; HGF -> fghj by the 3b/4b table.
//   - The 6b block is chosen from the current RD.
//   - The 4b block is chosen from the RD after the 6b block; a non-neutral sub-block flips RD.
//   - D.7 uses 111000 at RD- and 000111 at RD+.
//   - D.x.7 uses A7 (0111 at RD-, 1000 at RD+) when x in {17,18,20} at RD-, or x in {11,13,14} at RD+.
//   - Otherwise D.x.7 uses P7.
//   - Legal K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7. K.x.7 always uses the A7 forms.
//   - An illegal K code is replaced by K28.5 at the current RD, with code_err = 1.
//  rd_out is registered state and is only updated at word launch.
// TESTING
//  1 Reset, valid_in=0:
//     - enc_out = 10'h17C and rd_out = 1 until the first launch.
//     - It then alternates 10'h283 (rd 0) / 10'h17C (rd 1) every 10 cycles, word_strb once per word.
//  2 After reset, send D0.0 (8'h00, k=0) at RD+:
//     - enc_out = 10'h346, rd_out stays 1.
//     - Then send D21.5 (8'hB5) x3: enc_out = 10'h155 each word, rd_out = 1.
//  3 From RD+, send D11.7 (8'hEB): enc_out = 10'h04B (A7 path), rd_out -> 0.
//  4 valid_in held high with bytes 0x01..0x05:
//     - Exactly one byte is accepted per 10 cycles, only when ready_out = 1.
//     - Bytes are encoded in order; no byte is lost or duplicated.
//  5 Send k_in=1 with 8'h00 (illegal K): K28.5 at current RD, code_err = 1 for one cycle, RD updated.
//  6 Assert rst at counter = 4 with a word launched:
//     - Next cycle enc_out = 10'h17C, rd_out = 1, word_strb = 0.
//     - The first ready_out appears 9 cycles after rst drops.

Source files
------------

// File: rtl/tx_8b10b_encoder.sv
// tx_8b10b_encoder
//   8b/10b line encoder feeding a 1-bit/clk serializer. A slot counter paces one
//   10-bit word every WORD_PERIOD cycles. The byte offered on the last cycle of a
//   slot is encoded with running disparity and held for the next slot. Empty slots
//   carry IDLE_K so the line always has a valid code.
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   data_in[7:0]    byte HGF_EDCBA (bit 0 = A)
//   k_in            data_in is a control code
//   valid_in        data_in/k_in are offered
//   ready_out       byte is taken this cycle if valid_in (last cycle of the slot)
//   enc_out[9:0]    code word, bit 0 = 'a' (first on the line), order abcdei_fghj
//   word_strb       first cycle of a new enc_out
//   rd_out          running disparity after enc_out (1 = RD+)
//   code_err        with word_strb: an illegal K code was replaced by K28.5
module tx_8b10b_encoder #(
  parameter int unsigned WORD_PERIOD = 10,
  parameter logic [7:0]  IDLE_K      = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       k_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [9:0] enc_out,
  output logic       word_strb,
  output logic       rd_out,
  output logic       code_err
);

  localparam int unsigned    CW   = $clog2(WORD_PERIOD);
  localparam logic [CW-1:0]  LAST = CW'(WORD_PERIOD - 1);

  // 5b/6b RD- column, written abcdei with 'a' as the MSB.
  function automatic logic [5:0] f_6b(input logic [4:0] x);
    case (x)
      5'd0:  f_6b = 6'b100111;  5'd1:  f_6b = 6'b011101;
      5'd2:  f_6b = 6'b101101;  5'd3:  f_6b = 6'b110001;
      5'd4:  f_6b = 6'b110101;  5'd5:  f_6b = 6'b101001;
      5'd6:  f_6b = 6'b011001;  5'd7:  f_6b = 6'b111000;
      5'd8:  f_6b = 6'b111001;  5'd9:  f_6b = 6'b100101;
      5'd10: f_6b = 6'b010101;  5'd11: f_6b = 6'b110100;
      5'd12: f_6b = 6'b001101;  5'd13: f_6b = 6'b101100;
      5'd14: f_6b = 6'b011100;  5'd15: f_6b = 6'b010111;
      5'd16: f_6b = 6'b011011;  5'd17: f_6b = 6'b100011;
      5'd18: f_6b = 6'b010011;  5'd19: f_6b = 6'b110010;
      5'd20: f_6b = 6'b001011;  5'd21: f_6b = 6'b101010;
      5'd22: f_6b = 6'b011010;  5'd23: f_6b = 6'b111010;
      5'd24: f_6b = 6'b110011;  5'd25: f_6b = 6'b100110;
      5'd26: f_6b = 6'b010110;  5'd27: f_6b = 6'b110110;
      5'd28: f_6b = 6'b001110;  5'd29: f_6b = 6'b101110;
      5'd30: f_6b = 6'b011110;  default: f_6b = 6'b101011;
    endcase
  endfunction

  // 3b/4b RD- column for data (P7 in slot 7), fghj with 'f' as the MSB.
  function automatic logic [3:0] f_4b_d(input logic [2:0] y);
    case (y)
      3'd0: f_4b_d = 4'b1011;  3'd1: f_4b_d = 4'b1001;
      3'd2: f_4b_d = 4'b0101;  3'd3: f_4b_d = 4'b1100;
      3'd4: f_4b_d = 4'b1101;  3'd5: f_4b_d = 4'b1010;
      3'd6: f_4b_d = 4'b0110;  default: f_4b_d = 4'b1110;
    endcase
  endfunction

  // 3b/4b RD- column for control codes; RD+ is always the complement.
  function automatic logic [3:0] f_4b_k(input logic [2:0] y);
    case (y)
      3'd0: f_4b_k = 4'b1011;  3'd1: f_4b_k = 4'b0110;
      3'd2: f_4b_k = 4'b1010;  3'd3: f_4b_k = 4'b1100;
      3'd4: f_4b_k = 4'b1101;  3'd5: f_4b_k = 4'b0101;
      3'd6: f_4b_k = 4'b1001;  default: f_4b_k = 4'b0111;
    endcase
  endfunction

  logic [CW-1:0] r_cnt;
  logic [9:0]    r_enc;
  logic          r_rd, r_strb, r_err;

  logic       w_last, w_xfer, w_k, w_k_legal, w_err;
  logic [7:0] w_sym;
  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [5:0] w_6m, w_6;
  logic [3:0] w_4m, w_4;
  logic       w_6unbal, w_4unbal, w_rd6, w_a7, w_rd_nxt;
  logic [9:0] w_seq, w_code;

  assign w_last    = (r_cnt == LAST);
  assign w_xfer    = valid_in & w_last;
  assign ready_out = w_last;

  always_comb begin
    w_sym = w_xfer ? data_in : IDLE_K;
    w_k   = w_xfer ? k_in    : 1'b1;
    w_k_legal = (w_sym[4:0] == 5'd28) ||
                ((w_sym[7:5] == 3'd7) && (w_sym[4:0] == 5'd23 || w_sym[4:0] == 5'd27 ||
                                           w_sym[4:0] == 5'd29 || w_sym[4:0] == 5'd30));
    w_err = w_k & ~w_k_legal;
    // an illegal K is sent as K28.5
    w_x   = w_err ? 5'd28 : w_sym[4:0];
    w_y   = w_err ? 3'd5  : w_sym[7:5];

    w_6m     = (w_k && w_x == 5'd28) ? 6'b001111 : f_6b(w_x);
    w_6unbal = ($countones(w_6m) != 3);
    // D.7 is balanced but still has a distinct RD+ form
    w_6      = (r_rd && (w_6unbal || (!w_k && w_x == 5'd7))) ? ~w_6m : w_6m;
    w_rd6    = r_rd ^ w_6unbal;

    // A7 avoids a run of five equal bits across the 6b/4b boundary
    w_a7 = w_rd6 ? (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)
                 : (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20);
    if (w_k)                    w_4m = f_4b_k(w_y);
    else if (w_y == 3'd7 && w_a7) w_4m = 4'b0111;
    else                        w_4m = f_4b_d(w_y);
    w_4unbal = ($countones(w_4m) != 2);
    // D.x.3 and every K sub-block swap form at RD+ even when balanced
    w_4      = (w_rd6 && (w_k || w_4unbal || w_y == 3'd3)) ? ~w_4m : w_4m;
    w_rd_nxt = w_rd6 ^ w_4unbal;

    // tables hold 'a' at the MSB; the line wants 'a' at bit 0
    w_seq  = {w_6, w_4};
    w_code = '0;
    for (int i = 0; i < 10; i++) w_code[i] = w_seq[9-i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_enc  <= 10'h17C;
      r_rd   <= 1'b1;
      r_strb <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_strb <= 1'b0;
      r_err  <= 1'b0;
      if (w_last) begin
        r_cnt  <= '0;
        r_enc  <= w_code;
        r_rd   <= w_rd_nxt;
        r_strb <= 1'b1;
        r_err  <= w_err;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign enc_out   = r_enc;
  assign rd_out    = r_rd;
  assign word_strb = r_strb;
  assign code_err  = r_err;

endmodule

// File: tb/tb_tx_8b10b_encoder.sv
module tb_tx_8b10b_encoder;
  localparam int WP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       k_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out, word_strb, rd_out, code_err;
  logic [9:0] enc_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_8b10b_encoder #(.WORD_PERIOD(WP), .IDLE_K(8'hBC)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .k_in(k_in), .valid_in(valid_in),
    .ready_out(ready_out), .enc_out(enc_out), .word_strb(word_strb),
    .rd_out(rd_out), .code_err(code_err)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [9:0] code; logic rd; logic err; } enc_t;

  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T4D [8] = '{6'b1011, 6'b1001, 6'b0101, 6'b1100,
                                     6'b1101, 6'b1010, 6'b0110, 6'b1110};
  localparam logic [5:0] T4K [8] = '{6'b1011, 6'b0110, 6'b1010, 6'b1100,
                                     6'b1101, 6'b0101, 6'b1001, 6'b0111};

  // Picks the form of an n-bit sub-block (right aligned) that keeps the
  // cumulative ones-minus-zeros count of the line within +/-1.
  function automatic logic [5:0] pick(input logic [5:0] w, input int n, input bit alt,
                                      input int disp);
    logic [5:0] mask = (n == 6) ? 6'h3F : 6'h0F;
    int d = 2 * $countones(w) - n;
    if (d != 0) return (disp + d > 1 || disp + d < -1) ? (~w & mask) : w;
    return (alt && disp > 0) ? (~w & mask) : w;
  endfunction

  function automatic enc_t model_enc(input logic [7:0] d, input bit k, input bit rd);
    enc_t r;
    int disp, x, y;
    logic [5:0] b6, b4;
    logic [9:0] seq;
    r.err = 1'b0;
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    if (k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)))) begin
      r.err = 1'b1; x = 28; y = 5;
    end
    disp = rd ? 1 : -1;
    b6 = (k && x == 28) ? 6'b001111 : T6[x];
    b6 = pick(b6, 6, (!k && x == 7), disp);
    disp += 2 * $countones(b6) - 6;
    if (k) b4 = T4K[y];
    else if (y == 7 && ((disp < 0 && (x == 17 || x == 18 || x == 20)) ||
                        (disp > 0 && (x == 11 || x == 13 || x == 14)))) b4 = 6'b0111;
    else b4 = T4D[y];
    b4 = pick(b4, 4, (k || y == 3), disp);
    disp += 2 * $countones(b4) - 4;
    seq = {b6, b4[3:0]};
    for (int i = 0; i < 10; i++) r.code[i] = seq[9-i];
    r.rd = (disp > 0);
    return r;
  endfunction

  logic [3:0] m_cnt;
  bit         m_rd;
  logic [9:0] exp_enc;
  bit         exp_strb, exp_err;
  int         m_acc = 0;
  enc_t       m_next;
  wire        m_ready = (m_cnt == 4'(WP - 1));

  always_comb m_next = valid_in ? model_enc(data_in, k_in, m_rd) : model_enc(8'hBC, 1'b1, m_rd);

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= '0; m_rd <= 1'b1; exp_enc <= 10'h17C; exp_strb <= 1'b0; exp_err <= 1'b0;
    end else begin
      exp_strb <= 1'b0; exp_err <= 1'b0;
      if (m_ready) begin
        m_cnt <= '0; exp_enc <= m_next.code; m_rd <= m_next.rd;
        exp_err <= m_next.err; exp_strb <= 1'b1;
        if (valid_in) m_acc <= m_acc + 1;
      end else begin
        m_cnt <= m_cnt + 4'd1;
      end
    end
  end

  // Offers a byte and holds it until the handshake completes; returns at the
  // negedge just after the launch edge with valid_in dropped.
  task automatic send_byte(input logic [7:0] d, input bit k, output bit ok);
    data_in = d; k_in = k; valid_in = 1'b1; ok = 1'b0;
    for (int i = 0; i < 2 * WP + 2; i++) begin
      if (ready_out) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    valid_in = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (enc_out !== 10'h17C) begin bad++; $display("FAIL reset_enc got=%h want=17c", enc_out); end
    total++; if (rd_out !== 1'b1) begin bad++; $display("FAIL reset_rd got=%b want=1", rd_out); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_out); end
    total++; if (word_strb !== 1'b0) begin bad++; $display("FAIL reset_strb got=%b want=0", word_strb); end
    total++; if (code_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", code_err); end
  endtask

  task automatic test_idle;
    int nw = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      total++;
      if ({enc_out, rd_out, word_strb, ready_out} !== {exp_enc, m_rd, exp_strb, m_ready}) begin
        bad++; $display("FAIL idle_cycle%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", c, enc_out, rd_out,
                        word_strb, ready_out, exp_enc, m_rd, exp_strb, m_ready);
      end
      if (word_strb) begin
        nw++;
        total++;
        if (nw == 1 && {enc_out, rd_out} !== {10'h283, 1'b0}) begin
          bad++; $display("FAIL idle_word1 got=%h/%b want=283/0", enc_out, rd_out);
        end else if (nw == 2 && {enc_out, rd_out} !== {10'h17C, 1'b1}) begin
          bad++; $display("FAIL idle_word2 got=%h/%b want=17c/1", enc_out, rd_out);
        end
        if (c != 10 * nw) begin bad++; $display("FAIL idle_strb_time got=%0d want=%0d", c, 10 * nw); end
      end
    end
    total++; if (nw != 2) begin bad++; $display("FAIL idle_words got=%0d want=2", nw); end
  endtask

  task automatic test_data_fixed;
    bit ok;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    send_byte(8'h00, 1'b0, ok);
    total++;
    if (!ok || {enc_out, rd_out, word_strb, code_err} !== {10'h346, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL d0_0 ok=%b got=%h/%b/%b/%b want=346/1/1/0", ok, enc_out, rd_out, word_strb, code_err);
    end
    for (int n = 0; n < 3; n++) begin
      send_byte(8'hB5, 1'b0, ok);
      total++;
      if (!ok || {enc_out, rd_out, word_strb} !== {10'h155, 1'b1, 1'b1}) begin
        bad++; $display("FAIL d21_5_%0d ok=%b got=%h/%b/%b want=155/1/1", n, ok, enc_out, rd_out, word_strb);
      end
    end
  endtask

  task automatic test_a7;
    bit ok;
    send_byte(8'hEB, 1'b0, ok);
    total++;
    if (!ok || {enc_out, rd_out, word_strb} !== {10'h04B, 1'b0, 1'b1}) begin
      bad++; $display("FAIL d11_7 ok=%b got=%h/%b/%b want=04b/0/1", ok, enc_out, rd_out, word_strb);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int idx = 0, acc0 = m_acc, last_rdy = -1;
    bit prev_rdy = 1'b0;
    data_in = q[0]; k_in = 1'b0; valid_in = 1'b1;
    for (int c = 0; c < 6 * WP + 5 && idx < 5; c++) begin
      @(negedge clk);
      total++;
      if ({ready_out, word_strb} !== {m_ready, exp_strb}) begin
        bad++; $display("FAIL b2b_hs c=%0d got=%b/%b want=%b/%b", c, ready_out, word_strb, m_ready, exp_strb);
      end
      if (exp_strb) begin
        total++;
        if ({enc_out, rd_out} !== {exp_enc, m_rd}) begin
          bad++; $display("FAIL b2b_word idx=%0d got=%h/%b want=%h/%b", idx, enc_out, rd_out, exp_enc, m_rd);
        end
      end
      if (ready_out) begin
        if (last_rdy >= 0) begin
          total++;
          if (c - last_rdy != WP) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", c - last_rdy, WP); end
        end
        last_rdy = c;
      end
      if (prev_rdy) begin
        idx++;
        if (idx < 5) data_in = q[idx]; else valid_in = 1'b0;
      end
      prev_rdy = ready_out;
    end
    valid_in = 1'b0;
    total++; if (idx != 5) begin bad++; $display("FAIL b2b_sent got=%0d want=5", idx); end
    total++; if (m_acc - acc0 != 5) begin bad++; $display("FAIL b2b_accepted got=%0d want=5", m_acc - acc0); end
  endtask

  task automatic test_illegal_k;
    logic [7:0] bytes [2] = '{8'h00, 8'hFF};
    bit ok, rd0;
    for (int n = 0; n < 2; n++) begin
      rd0 = m_rd;
      send_byte(bytes[n], 1'b1, ok);
      total++;
      if (!ok || {enc_out, rd_out, word_strb, code_err} !== {(rd0 ? 10'h283 : 10'h17C), ~rd0, 1'b1, 1'b1}) begin
        bad++; $display("FAIL illegal_k_%0d ok=%b got=%h/%b/%b/%b want=%h/%b/1/1", n, ok, enc_out,
                        rd_out, word_strb, code_err, (rd0 ? 10'h283 : 10'h17C), ~rd0);
      end
      @(negedge clk);
      total++;
      if ({word_strb, code_err} !== 2'b00) begin
        bad++; $display("FAIL illegal_k_pulse_%0d got=%b/%b want=0/0", n, word_strb, code_err);
      end
    end
  endtask

  task automatic test_specials;
    logic [7:0] sp [20] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                            8'hF7, 8'hFB, 8'hFD, 8'hFE,
                            8'hF1, 8'hF2, 8'hF4, 8'hEB, 8'hED, 8'hEE, 8'h67, 8'hE7};
    bit ok;
    for (int rep = 0; rep < 2; rep++) begin
      for (int n = 0; n < 20; n++) begin
        if (rep == 1 && n == 0) send_byte(8'h00, 1'b0, ok); // shift RD phase for the second pass
        send_byte(sp[n], (n < 12), ok);
        total++;
        if (!ok || {enc_out, rd_out, word_strb, code_err} !== {exp_enc, m_rd, 1'b1, 1'b0}) begin
          bad++; $display("FAIL special_%02h ok=%b got=%h/%b/%b/%b want=%h/%b/1/0", sp[n], ok, enc_out,
                          rd_out, word_strb, code_err, exp_enc, m_rd);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] kl [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                            8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] d;
    bit k, ok;
    int r;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      r = int'($urandom_range(0, 9));
      if (r < 6)      begin d = 8'($urandom); k = 1'b0; end
      else if (r < 9) begin d = kl[$urandom_range(0, 11)]; k = 1'b1; end
      else            begin d = 8'($urandom); k = 1'b1; end
      send_byte(d, k, ok);
      total++;
      if (!ok || {enc_out, rd_out, word_strb, code_err} !== {exp_enc, m_rd, 1'b1, exp_err}) begin
        bad++; $display("FAIL rand_%0d d=%h k=%b ok=%b got=%h/%b/%b/%b want=%h/%b/1/%b", n, d, k, ok,
                        enc_out, rd_out, word_strb, code_err, exp_enc, m_rd, exp_err);
      end
    end
  endtask

  task automatic test_reset_midword;
    bit ok;
    int n = 0;
    send_byte(8'h55, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_launch got=timeout want=launch"); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({enc_out, rd_out, word_strb, ready_out, code_err} !== {10'h17C, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midrst_values got=%h/%b/%b/%b/%b want=17c/1/0/0/0", enc_out, rd_out,
                      word_strb, ready_out, code_err);
    end
    rst = 1'b0;
    for (int c = 0; c < 2 * WP; c++) begin
      @(negedge clk);
      n++;
      if (ready_out) break;
    end
    total++; if (n != 9 || ready_out !== 1'b1) begin bad++; $display("FAIL midrst_first_ready got=%0d want=9", n); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_data_fixed();
    test_a7();
    test_back_to_back();
    test_illegal_k();
    test_specials();
    test_random();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
